cfo_corrector: RTL and testbench

Frequency-correction stage directly downstream of the CFO estimator. It accepts the estimator's DDS phase increment and runs a phase accumulator with a cos/sin LUT (the NCO). Each incoming complex baseband sample is rotated by the negative accumulated phase, removing the carrier frequency offset before the stream reaches the FFT/demodulation chain.

---
 rtl/cfo_pkg.sv | 29 ++
 rtl/cfo_corrector_dds_sincos_lut.sv | 41 ++++
 rtl/cfo_corrector.sv | 158 +++++++++++++++
 tb/tb_cfo_corrector.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cfo_pkg.sv
// Shared definitions for the CFO estimator/corrector pair: default widths, corrector
// state encoding and the complex sample packing (imag in upper half, real in lower half).
package cfo_pkg;

  localparam int CFO_DDS_DW    = 20;
  localparam int CFO_LUT_DW    = 16;
  localparam int CFO_SAMPLE_DW = 32;
  localparam int CFO_HALF_DW   = CFO_SAMPLE_DW / 2;

  typedef enum logic {
    BYPASS = 1'b0,
    TRACK  = 1'b1
  } cfo_state_e;

  typedef struct packed {
    logic signed [CFO_HALF_DW-1:0] im;
    logic signed [CFO_HALF_DW-1:0] re;
  } cfo_iq_t;

  function automatic logic [CFO_SAMPLE_DW-1:0] cfo_pack(input logic signed [CFO_HALF_DW-1:0] re,
                                                         input logic signed [CFO_HALF_DW-1:0] im);
    return {im, re};
  endfunction

  function automatic cfo_iq_t cfo_unpack(input logic [CFO_SAMPLE_DW-1:0] s);
    return cfo_iq_t'(s);
  endfunction

endpackage

// File: rtl/cfo_corrector_dds_sincos_lut.sv
// Quarter-free full-circle cos/sin ROM for the NCO: registered address in, registered
// cos/sin out (one cycle). Table contents are computed at elaboration time.
module dds_sincos_lut #(
  parameter int LUT_AW = 10,
  parameter int LUT_DW = 16
) (
  input  logic                     clk_i,
  input  logic [LUT_AW-1:0]        addr_i,
  output logic signed [LUT_DW-1:0] cos_o,
  output logic signed [LUT_DW-1:0] sin_o
);

  localparam int DEPTH = 1 << LUT_AW;
  localparam int AMP   = (1 << (LUT_DW - 1)) - 1;

  function automatic logic signed [LUT_DW-1:0] lut_entry(input int k, input bit want_sin);
    real ang;
    real v;
    ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(DEPTH);
    v   = real'(AMP) * (want_sin ? $sin(ang) : $cos(ang));
    // round half away from zero
    v   = (v >= 0.0) ? $floor(v + 0.5) : -$floor(-v + 0.5);
    return LUT_DW'($rtoi(v));
  endfunction

  logic signed [LUT_DW-1:0] cos_rom [DEPTH];
  logic signed [LUT_DW-1:0] sin_rom [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    localparam logic signed [LUT_DW-1:0] COS_V = lut_entry(gi, 1'b0);
    localparam logic signed [LUT_DW-1:0] SIN_V = lut_entry(gi, 1'b1);
    assign cos_rom[gi] = COS_V;
    assign sin_rom[gi] = SIN_V;
  end

  always_ff @(posedge clk_i) begin
    cos_o <= cos_rom[addr_i];
    sin_o <= sin_rom[addr_i];
  end

endmodule

// File: rtl/cfo_corrector.sv
// Carrier frequency offset corrector: NCO phase accumulator + cos/sin LUT derotating each
// sample by the accumulated phase. Define CFO_CORRECTOR_ACCUM_EN for closed-loop increment accumulation.
module cfo_corrector
  import cfo_pkg::*;
#(
  parameter int IN_DW  = 32,
  parameter int OUT_DW = 32,
  parameter int DDS_DW = CFO_DDS_DW,
  parameter int LUT_AW = 10,
  parameter int LUT_DW = CFO_LUT_DW
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [IN_DW-1:0]  s_axis_in_tdata,
  input  logic              s_axis_in_tvalid,
  input  logic [DDS_DW-1:0] CFO_DDS_inc_i,
  input  logic              CFO_DDS_inc_valid_i,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  output logic [DDS_DW-1:0] active_inc_o
);

  localparam int IHW   = IN_DW / 2;
  localparam int OHW   = OUT_DW / 2;
  localparam int PW    = IHW + LUT_DW + 1;
  localparam int ROUND = 1 << (LUT_DW - 2);

  localparam logic signed [PW-1:0]  SAT_MAX   = {{(PW-OHW+1){1'b0}}, {(OHW-1){1'b1}}};
  localparam logic signed [PW-1:0]  SAT_MIN   = {{(PW-OHW+1){1'b1}}, {(OHW-1){1'b0}}};
  localparam logic signed [OHW-1:0] SAT_MAX_O = {1'b0, {(OHW-1){1'b1}}};
  localparam logic signed [OHW-1:0] SAT_MIN_O = {1'b1, {(OHW-1){1'b0}}};

  function automatic logic signed [OHW-1:0] round_sat(input logic signed [PW-1:0] full);
    logic signed [PW-1:0] rounded;
    rounded = (full + PW'(ROUND)) >>> (LUT_DW - 1);
    if (rounded > SAT_MAX) return SAT_MAX_O;
    if (rounded < SAT_MIN) return SAT_MIN_O;
    return OHW'(rounded);
  endfunction

  // ---------------- NCO control ----------------
  cfo_state_e        state_q, state_d;
  logic [DDS_DW-1:0] phase_acc_q, phase_acc_d;
  logic [DDS_DW-1:0] active_inc_q, active_inc_d;

  always_comb begin
    state_d      = state_q;
    phase_acc_d  = phase_acc_q;
    active_inc_d = active_inc_q;
    // the advance always uses the increment held before any same-cycle strobe
    if (s_axis_in_tvalid && (state_q == TRACK)) begin
      phase_acc_d = phase_acc_q + active_inc_q;
    end
    if (CFO_DDS_inc_valid_i) begin
      state_d = TRACK;
`ifdef CFO_CORRECTOR_ACCUM_EN
      active_inc_d = active_inc_q + CFO_DDS_inc_i;
`else
      active_inc_d = CFO_DDS_inc_i;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q      <= BYPASS;
      phase_acc_q  <= '0;
      active_inc_q <= '0;
    end else begin
      state_q      <= state_d;
      phase_acc_q  <= phase_acc_d;
      active_inc_q <= active_inc_d;
    end
  end

  assign active_inc_o = active_inc_q;

  // ---------------- S1: sample + LUT address ----------------
  logic              s1_valid_q;
  logic [IN_DW-1:0]  s1_data_q;
  logic [LUT_AW-1:0] lut_addr_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      lut_addr_q <= '0;
    end else begin
      s1_valid_q <= s_axis_in_tvalid;
      s1_data_q  <= s_axis_in_tdata;
      lut_addr_q <= phase_acc_q[DDS_DW-1 -: LUT_AW];
    end
  end

  // ---------------- S2: LUT read ----------------
  logic signed [LUT_DW-1:0] lut_cos, lut_sin;
  logic                     s2_valid_q;
  logic [IN_DW-1:0]         s2_data_q;

  dds_sincos_lut #(
    .LUT_AW(LUT_AW),
    .LUT_DW(LUT_DW)
  ) u_lut (
    .clk_i (clk_i),
    .addr_i(lut_addr_q),
    .cos_o (lut_cos),
    .sin_o (lut_sin)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_data_q  <= s1_data_q;
    end
  end

  // ---------------- S3: complex multiply by (cos - j sin) ----------------
  logic signed [IHW-1:0] s2_re, s2_im;
  logic signed [PW-1:0]  re_x, im_x, cos_x, sin_x;
  logic signed [PW-1:0]  re_full_d, im_full_d, re_full_q, im_full_q;
  logic                  s3_valid_q;

  assign s2_re     = s2_data_q[IHW-1:0];
  assign s2_im     = s2_data_q[IN_DW-1 -: IHW];
  assign re_x      = PW'(s2_re);
  assign im_x      = PW'(s2_im);
  assign cos_x     = PW'(lut_cos);
  assign sin_x     = PW'(lut_sin);
  assign re_full_d = re_x * cos_x + im_x * sin_x;
  assign im_full_d = im_x * cos_x - re_x * sin_x;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      s3_valid_q <= 1'b0;
      re_full_q  <= '0;
      im_full_q  <= '0;
    end else begin
      s3_valid_q <= s2_valid_q;
      re_full_q  <= re_full_d;
      im_full_q  <= im_full_d;
    end
  end

  // ---------------- S4: round, saturate, output ----------------
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      m_axis_out_tvalid <= 1'b0;
      m_axis_out_tdata  <= '0;
    end else begin
      m_axis_out_tvalid <= s3_valid_q;
      m_axis_out_tdata  <= {round_sat(im_full_q), round_sat(re_full_q)};
    end
  end

endmodule

// File: tb/tb_cfo_corrector.sv
// Self-checking bench for cfo_corrector: directed steps plus randomized traffic compared
// against an arithmetic model of the derotation with a 4-deep latency line.
module tb_cfo_corrector;
  import cfo_pkg::*;

  localparam int DDS_DW = 20;
  localparam int LUT_AW = 10;
  localparam int MASK   = (1 << DDS_DW) - 1;
  localparam real PI    = 3.14159265358979323846;
`ifdef CFO_CORRECTOR_ACCUM_EN
  localparam bit ACCUM = 1'b1;
`else
  localparam bit ACCUM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_ni = 1'b0;
  logic [31:0]       s_axis_in_tdata = '0;
  logic              s_axis_in_tvalid = 1'b0;
  logic [DDS_DW-1:0] CFO_DDS_inc_i = '0;
  logic              CFO_DDS_inc_valid_i = 1'b0;
  logic [31:0]       m_axis_out_tdata;
  logic              m_axis_out_tvalid;
  logic [DDS_DW-1:0] active_inc_o;

  always #5 clk = ~clk;

  cfo_corrector dut (
    .clk_i              (clk),
    .reset_ni           (reset_ni),
    .s_axis_in_tdata    (s_axis_in_tdata),
    .s_axis_in_tvalid   (s_axis_in_tvalid),
    .CFO_DDS_inc_i      (CFO_DDS_inc_i),
    .CFO_DDS_inc_valid_i(CFO_DDS_inc_valid_i),
    .m_axis_out_tdata   (m_axis_out_tdata),
    .m_axis_out_tvalid  (m_axis_out_tvalid),
    .active_inc_o       (active_inc_o)
  );

  typedef struct {
    bit          valid;
    logic [31:0] data;
    bit          has_ideal;
    int          ire;
    int          iim;
  } exp_t;

  exp_t        pipe[$];
  int unsigned m_phase;
  int unsigned m_inc;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic longint rnd(input real x);
    if (x >= 0.0) return longint'($rtoi($floor(x + 0.5)));
    return -longint'($rtoi($floor(-x + 0.5)));
  endfunction

  function automatic longint sat16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // out = in * exp(-j*angle), angle from the truncated top phase bits
  function automatic logic [31:0] model_rotate(input logic [31:0] din, input int unsigned ph);
    int unsigned addr;
    real         ang;
    longint      c, s, i, q, re, im;
    logic [15:0] r16, i16;
    cfo_iq_t     smp;
    smp  = cfo_unpack(din);
    addr = ph >> (DDS_DW - LUT_AW);
    ang  = 2.0 * PI * real'(addr) / real'(1 << LUT_AW);
    c    = rnd(32767.0 * $cos(ang));
    s    = rnd(32767.0 * $sin(ang));
    i    = longint'(smp.re);
    q    = longint'(smp.im);
    re   = sat16((i * c + q * s + 16384) >>> 15);
    im   = sat16((q * c - i * s + 16384) >>> 15);
    r16  = re[15:0];
    i16  = im[15:0];
    return cfo_pack(r16, i16);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int expv);
    n_cmp++;
    assert ((obs - expv <= 1) && (expv - obs <= 1)) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d +-1", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    exp_t e;
    e = '{valid: 1'b0, data: '0, has_ideal: 1'b0, ire: 0, iim: 0};
    pipe.delete();
    repeat (3) pipe.push_back(e);
    m_phase = 0;
    m_inc   = 0;
  endtask

  task automatic do_reset(input int cycles);
    reset_ni            = 1'b0;
    s_axis_in_tvalid    = 1'b1;
    CFO_DDS_inc_valid_i = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      s_axis_in_tdata = $urandom;
      @(posedge clk);
      #1;
      check("rst_valid", {31'd0, m_axis_out_tvalid}, 32'd0);
      check("rst_data", m_axis_out_tdata, 32'd0);
      check("rst_inc", {12'd0, active_inc_o}, 32'd0);
    end
    model_clear();
    reset_ni         = 1'b1;
    s_axis_in_tvalid = 1'b0;
  endtask

  task automatic step(input bit v, input int re, input int im, input bit stb, input int inc,
                      input bit hi, input int ire, input int iim);
    exp_t        e, o;
    logic [31:0] din;
    logic [15:0] r16, i16;
    cfo_iq_t     got;
    r16 = re[15:0];
    i16 = im[15:0];
    din = cfo_pack(r16, i16);
    s_axis_in_tvalid    = v;
    s_axis_in_tdata     = din;
    CFO_DDS_inc_valid_i = stb;
    CFO_DDS_inc_i       = inc[DDS_DW-1:0];
    e = '{valid: v, data: '0, has_ideal: hi, ire: ire, iim: iim};
    if (v) begin
      e.data  = model_rotate(din, m_phase);
      m_phase = (m_phase + m_inc) & MASK;
    end
    if (stb) m_inc = ACCUM ? ((m_inc + inc) & MASK) : (inc & MASK);
    pipe.push_back(e);
    @(posedge clk);
    #1;
    o = pipe.pop_front();
    check("out_valid", {31'd0, m_axis_out_tvalid}, {31'd0, o.valid});
    if (o.valid) check("out_data", m_axis_out_tdata, o.data);
    check("active_inc", {12'd0, active_inc_o}, m_inc);
    if (o.valid && o.has_ideal) begin
      got = cfo_unpack(m_axis_out_tdata);
      check_near("ideal_re", int'(got.re), o.ire);
      check_near("ideal_im", int'(got.im), o.iim);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  int q_re[4] = '{1000, 0, -1000, 0};
  int q_im[4] = '{0, -1000, 0, 1000};

  initial begin
    // reset with traffic present
    do_reset(3);

    // bypass: unity gain
    for (int k = 0; k < 10; k++) step(1'b1, 1000, -500, 1'b0, 0, 1'b1, 1000, -500);

    // reset with samples in flight, then quarter-turn tone
    do_reset(1);
    idle(4);
    step(1'b0, 0, 0, 1'b1, 1 << (DDS_DW - 2), 1'b0, 0, 0);
    for (int k = 0; k < 8; k++) step(1'b1, 1000, 0, 1'b0, 0, 1'b1, q_re[k % 4], q_im[k % 4]);
    // strobe inc=0 alongside a sample: that sample keeps phase 0, the next lands on -pi/2 and stays
    step(1'b1, 1000, 0, 1'b1, 0, 1'b1, 1000, 0);
    for (int k = 0; k < 5; k++) step(1'b1, 1000, 0, 1'b0, 0, 1'b1, 0, -1000);
    idle(4);

    // saturation at pi/4
    do_reset(1);
    step(1'b0, 0, 0, 1'b1, 1 << (DDS_DW - 3), 1'b0, 0, 0);
    step(1'b1, 32767, 32767, 1'b0, 0, 1'b0, 0, 0);
    step(1'b1, 32767, 32767, 1'b0, 0, 1'b1, 32767, 0);
    idle(4);

    // increment replace vs accumulate
    do_reset(1);
    step(1'b0, 0, 0, 1'b1, 1 << (DDS_DW - 3), 1'b0, 0, 0);
    step(1'b0, 0, 0, 1'b1, 1 << (DDS_DW - 3), 1'b0, 0, 0);
    check("accum_inc", {12'd0, active_inc_o},
          ACCUM ? 32'(1 << (DDS_DW - 2)) : 32'(1 << (DDS_DW - 3)));

    // randomized traffic with gaps, strobes and one mid-stream reset
    for (int k = 0; k < 500; k++) begin
      if (k == 250) do_reset(2);
      step($urandom_range(0, 3) != 0, int'($urandom), int'($urandom),
           $urandom_range(0, 15) == 0, int'($urandom), 1'b0, 0, 0);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
